// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: single req/ack data-memory access
// with pipeline stall, store lane formatting and load extraction/extension.
module mem_access_unit #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  instr_id_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_done,
  output logic        misaligned_out
);

  localparam logic [5:0] INSTR_LB  = 6'd10;
  localparam logic [5:0] INSTR_LH  = 6'd11;
  localparam logic [5:0] INSTR_LW  = 6'd12;
  localparam logic [5:0] INSTR_LBU = 6'd13;
  localparam logic [5:0] INSTR_LHU = 6'd14;
  localparam logic [5:0] INSTR_SB  = 6'd15;
  localparam logic [5:0] INSTR_SH  = 6'd16;
  localparam logic [5:0] INSTR_SW  = 6'd17;

  if (TIMEOUT != 0) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT is reserved and must be 0");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic [5:0] op;
  logic [1:0] lo;

  function automatic logic is_load_id(input logic [5:0] id);
    return (id == INSTR_LB) || (id == INSTR_LH) || (id == INSTR_LW) ||
           (id == INSTR_LBU) || (id == INSTR_LHU);
  endfunction

  function automatic logic is_store_id(input logic [5:0] id);
    return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
  endfunction

  logic        in_load, in_store, misaligned, req_ok, accept;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] fmt_load;

  always_comb begin
    in_load    = is_load_id(instr_id_in);
    in_store   = is_store_id(instr_id_in);
    misaligned = (((instr_id_in == INSTR_LH) || (instr_id_in == INSTR_LHU) ||
                   (instr_id_in == INSTR_SH)) && addr_in[0]) ||
                 (((instr_id_in == INSTR_LW) || (instr_id_in == INSTR_SW)) &&
                  (addr_in[1:0] != 2'b00));
    req_ok     = (state == IDLE) && valid_in && (in_load || in_store);
    accept     = req_ok && !misaligned;
  end

  // The accept term lets the stall reach IF..MEM in the same cycle the op arrives.
  assign stall_out = !rst && ((state == ACCESS) || accept);

  always_comb begin
    fmt_wdata = 32'h0;
    fmt_wstrb = 4'b0000;
    case (instr_id_in)
      INSTR_SB: begin
        fmt_wdata = {4{store_data_in[7:0]}};
        fmt_wstrb = 4'b0001 << addr_in[1:0];
      end
      INSTR_SH: begin
        fmt_wdata = {2{store_data_in[15:0]}};
        fmt_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
      end
      INSTR_SW: begin
        fmt_wdata = store_data_in;
        fmt_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_lane = dmem_rdata[{lo, 3'b000} +: 8];
    half_lane = dmem_rdata[{lo[1], 4'b0000} +: 16];
    case (op)
      INSTR_LB:  fmt_load = {{24{byte_lane[7]}}, byte_lane};
      INSTR_LBU: fmt_load = {24'h0, byte_lane};
      INSTR_LH:  fmt_load = {{16{half_lane[15]}}, half_lane};
      INSTR_LHU: fmt_load = {16'h0, half_lane};
      default:   fmt_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op             <= 6'h0;
      lo             <= 2'b00;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'h0;
      dmem_wdata     <= 32'h0;
      dmem_wstrb     <= 4'b0000;
      load_data_out  <= 32'h0;
      load_done      <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      load_done      <= 1'b0;
      misaligned_out <= 1'b0;
      case (state)
        IDLE: begin
          misaligned_out <= req_ok && misaligned;
          if (accept) begin
            state      <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= in_store;
            dmem_addr  <= {addr_in[31:2], 2'b00};
            dmem_wdata <= fmt_wdata;
            dmem_wstrb <= fmt_wstrb;
            op         <= instr_id_in;
            lo         <= addr_in[1:0];
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (is_load_id(op)) begin
              load_data_out <= fmt_load;
              load_done     <= 1'b1;
            end
          end
        end
        // The finished op still occupies MEM this cycle, so nothing is accepted.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a
// behavioural load/store formatting model and randomized ops.
module tb_mem_access_unit;

  localparam logic [5:0] LB  = 6'd10;
  localparam logic [5:0] LH  = 6'd11;
  localparam logic [5:0] LW  = 6'd12;
  localparam logic [5:0] LBU = 6'd13;
  localparam logic [5:0] LHU = 6'd14;
  localparam logic [5:0] SB  = 6'd15;
  localparam logic [5:0] SH  = 6'd16;
  localparam logic [5:0] SW  = 6'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [5:0]  instr_id_in = 6'd0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] store_data_in = 32'h0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_done, misaligned_out;

  int checks = 0;
  int fails  = 0;
  logic [31:0] model_load = 32'h0;

  mem_access_unit #(.TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_id_in(instr_id_in),
    .addr_in(addr_in), .store_data_in(store_data_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_out(stall_out), .load_data_out(load_data_out), .load_done(load_done),
    .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  function automatic bit is_load(input logic [5:0] id);
    return id >= LB && id <= LHU;
  endfunction

  function automatic bit is_mem(input logic [5:0] id);
    return id >= LB && id <= SW;
  endfunction

  function automatic bit is_misaligned(input logic [5:0] id, input logic [31:0] a);
    if (id == LH || id == LHU || id == SH) return a % 2 != 0;
    if (id == LW || id == SW) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] id, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (id)
      LB:      return (b >= 32'd128) ? b - 32'd256 : b;
      LBU:     return b;
      LH:      return (h >= 32'd32768) ? h - 32'h10000 : h;
      LHU:     return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] id, input logic [31:0] d);
    case (id)
      SB:      return (d & 32'hFF) * 32'h01010101;
      SH:      return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [5:0] id, input logic [31:0] a);
    case (id)
      SB:      return 4'(1 << (a % 4));
      SH:      return ((a / 2) % 2 != 0) ? 4'b1100 : 4'b0011;
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // One instruction presented in MEM; d = req cycles before the ack cycle.
  task automatic run_op(input logic [5:0] id, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int d);
    bit acc, ld, mis;
    int stalls;
    acc = is_mem(id) && !is_misaligned(id, a);
    mis = is_mem(id) && is_misaligned(id, a);
    ld  = is_load(id);
    stalls = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; instr_id_in = id; addr_in = a; store_data_in = sd;
    dmem_ack = 1'b0; dmem_rdata = rd;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b expected 0", dmem_req); end
    checks++;
    if (stall_out !== acc) begin fails++; $display("FAIL accept_stall id=%0d addr=%h: got %b expected %b", id, a, stall_out, acc); end
    checks++;
    if (load_data_out !== model_load) begin fails++; $display("FAIL hold_data: got %h expected %h", load_data_out, model_load); end
    checks++;
    if (load_done !== 1'b0 || misaligned_out !== 1'b0) begin fails++; $display("FAIL idle_pulses: got done=%b mis=%b expected 0 0", load_done, misaligned_out); end
    if (stall_out) stalls++;
    if (!acc) begin
      @(posedge clk); #1; valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (misaligned_out !== mis) begin fails++; $display("FAIL misaligned_pulse id=%0d addr=%h: got %b expected %b", id, a, misaligned_out, mis); end
      checks++;
      if (dmem_req !== 1'b0 || stall_out !== 1'b0 || load_done !== 1'b0) begin
        fails++; $display("FAIL reject_quiet: got req=%b stall=%b done=%b expected 0 0 0", dmem_req, stall_out, load_done);
      end
      return;
    end
    for (int i = 0; i <= d; i++) begin
      @(posedge clk); #1;
      valid_in = 1'($urandom); instr_id_in = 6'($urandom); addr_in = $urandom;
      dmem_ack = (i == d);
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin fails++; $display("FAIL access_req_stall: got req=%b stall=%b expected 1 1", dmem_req, stall_out); end
      checks++;
      if (dmem_addr !== {a[31:2], 2'b00} || dmem_we !== !ld || dmem_wstrb !== ref_wstrb(id, a)) begin
        fails++; $display("FAIL access_fields: got addr=%h we=%b strb=%b expected %h %b %b",
                          dmem_addr, dmem_we, dmem_wstrb, {a[31:2], 2'b00}, !ld, ref_wstrb(id, a));
      end
      if (!ld) begin
        checks++;
        if (dmem_wdata !== ref_wdata(id, sd)) begin fails++; $display("FAIL store_wdata: got %h expected %h", dmem_wdata, ref_wdata(id, sd)); end
      end
      if (stall_out) stalls++;
    end
    @(posedge clk); #1;
    dmem_ack = 1'($urandom);
    valid_in = 1'b1; instr_id_in = id; addr_in = a;
    if (ld) model_load = ref_load(id, a, rd);
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL done_quiet: got stall=%b req=%b expected 0 0", stall_out, dmem_req); end
    checks++;
    if (load_done !== ld) begin fails++; $display("FAIL done_pulse: got %b expected %b", load_done, ld); end
    checks++;
    if (load_data_out !== model_load) begin fails++; $display("FAIL load_data id=%0d addr=%h: got %h expected %h", id, a, load_data_out, model_load); end
    checks++;
    if (stalls != d + 2) begin fails++; $display("FAIL stall_cycles: got %0d expected %0d", stalls, d + 2); end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; instr_id_in = LW; addr_in = 32'h100;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0) begin
      fails++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h strb=%b expected all zero", dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
    end
    checks++;
    if (stall_out !== 1'b0 || load_data_out !== 32'h0 || load_done !== 1'b0 || misaligned_out !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got stall=%b data=%h done=%b mis=%b expected all zero", stall_out, load_data_out, load_done, misaligned_out);
    end
    #2 rst = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_lw_wait();
    run_op(LW, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    go_idle();
  endtask

  task automatic test_load_extract();
    run_op(LB,  32'h103, 32'h0, 32'h80FF7F01, 1);
    run_op(LBU, 32'h103, 32'h0, 32'h80FF7F01, 0);
    run_op(LH,  32'h102, 32'h0, 32'h80FF7F01, 1);
    run_op(LHU, 32'h102, 32'h0, 32'h80FF7F01, 0);
    go_idle();
  endtask

  task automatic test_stores();
    run_op(SB, 32'h201, 32'h12345678, $urandom, 1);
    run_op(SH, 32'h202, 32'h12345678, $urandom, 2);
    go_idle();
  endtask

  task automatic test_misaligned();
    run_op(LW, 32'h102, 32'h0, 32'h0, 0);
    run_op(SH, 32'h301, 32'h0, 32'h0, 0);
    run_op(6'd3, 32'h400, 32'h0, 32'h0, 0);
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_op(LW, 32'h500, 32'h0, 32'hCAFEF00D, 0);
    run_op(SW, 32'h504, 32'hA5A5_5A5A, 32'h0, 0);
    run_op(LW, 32'h504, 32'h0, 32'h0BADF00D, 0);
    go_idle();
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    valid_in = 1'b1; instr_id_in = LW; addr_in = 32'h40;
    @(posedge clk); #1; valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin fails++; $display("FAIL mid_access_req: got %b expected 1", dmem_req); end
    #2 rst = 1'b1;
    model_load = 32'h0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || load_data_out !== 32'h0) begin
      fails++; $display("FAIL async_reset: got req=%b stall=%b data=%h expected 0 0 0", dmem_req, stall_out, load_data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL stale_ack: got done=%b req=%b expected 0 0", load_done, dmem_req); end
    run_op(LW, 32'h44, 32'h0, 32'h55667788, 1);
    go_idle();
  endtask

  task automatic test_random();
    logic [5:0] id;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      id = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(10, 17));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (id == SB || id == LB || id == LBU) ? a[1:0] : 2'b00;
      run_op(id, a, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_extract();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- MEM-stage load/store unit: the producer side of the load-data path consumed at writeback.
- Accepts a memory instruction from the EX/MEM register and issues a single req/ack transaction to data memory.
- Stalls the pipeline until the transaction completes.
- Returns byte/half/word-extracted, sign- or zero-extended load data, held stable for the WB stage.

## Interface
Parameters
- TIMEOUT, 0: reserved, must be 0; no bus timeout is implemented.

Ports
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  MEM-stage instruction valid
- instr_id_in  in  6  instruction ID from instr_defines.vh (INSTR_LB/LH/LW/LBU/LHU/SB/SH/SW are memory ops)
- addr_in  in  32  effective address computed by ALU
- store_data_in  in  32  rs2 value for stores
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte write strobes
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  transaction complete
- stall_out  out  1  hold IF..MEM stages
- load_data_out  out  32  formatted load result
- load_done  out  1  one-cycle pulse when load_data_out updates
- misaligned_out  out  1  one-cycle pulse when a misaligned access is rejected

## Operation
FSM states: IDLE, ACCESS, DONE.

IDLE
- A memory op with valid_in=1 and an aligned address is accepted.
- Latch dmem_addr, dmem_we, dmem_wdata, dmem_wstrb, op type and addr[1:0].
- Next state: ACCESS.
- Non-memory ops and valid_in=0: no action.

ACCESS
- dmem_req=1; all dmem_* outputs held stable.
- On dmem_ack=1, go to DONE.
- For loads, load_data_out is registered at that edge.

DONE
- Lasts one cycle, then returns to IDLE.
- No new op is accepted here, because the completed instruction is still in MEM this cycle.

Alignment
- LH/LHU/SH with addr[0]=1 is misaligned.
- LW/SW with addr[1:0]≠0 is misaligned.
- A misaligned op is not issued and does not stall.
- misaligned_out=1 on the next cycle. State stays IDLE; load_data_out is unchanged.

Store formatting
- SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
- SH: wdata={2{d[15:0]}}, wstrb=addr[1] ? 4'b1100 : 4'b0011.
- SW: wdata=d, wstrb=4'b1111.
- Loads: dmem_we=0, wstrb=4'b0000.

Load formatting
- Byte lane is rdata[8*addr[1:0] +: 8]; half lane is rdata[16*addr[1] +: 16].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through.

Stall and hazards
- stall_out = (state==ACCESS) | (state==IDLE & accept). The accept term is combinational from inputs.
- valid_in or instr_id_in changing during ACCESS is ignored; the transaction always completes.
- dmem_ack outside ACCESS is ignored.
- Stores never update load_data_out or pulse load_done.

## Timing
Reset values (all outputs forced low/zero immediately when rst asserts, including mid-transaction)
- state=IDLE
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0
- load_data_out=0, load_done=0, misaligned_out=0
- stall_out=0 while rst=1

Accept and latency
- Accept in cycle C: stall_out=1 in C; dmem_req=1 from C+1.
- Ack in cycle C+k (k≥1, ack may come in the first req cycle): DONE in C+k+1.
- In C+k+1: stall_out=0, load_done=1, load_data_out valid.
- Minimum load-to-data latency is 2 cycles after accept.

Hold and spacing
- load_data_out holds its value until the next load completes, so it remains valid during the following WB cycle.
- Back-to-back memory ops: the second op is accepted at the earliest in the cycle after DONE.

## Test plan
- LW from 0x100, memory returns 0xDEADBEEF with ack 3 cycles after req:
  - dmem_addr=0x100, we=0, wstrb=0.
  - stall_out high for 4 cycles.
  - load_done pulses; load_data_out=0xDEADBEEF.
- LB/LBU from addr 0x103, rdata=0x80FF7F01:
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - LH from 0x102 gives 0xFFFF80FF; LHU gives 0x000080FF.
- Stores, store_data_in=0x12345678:
  - SB at 0x201: wdata=0x78787878, wstrb=0010, dmem_addr=0x200, we=1.
  - SH at 0x202: wdata=0x56785678, wstrb=1100.
  - load_data_out unchanged; no load_done.
- Misaligned LW at 0x102 and SH at 0x301:
  - dmem_req stays 0; stall_out stays 0.
  - misaligned_out pulses once per op, one cycle later.
- Zero-wait ack plus back-to-back ops:
  - LW then SW with ack in the first req cycle.
  - Each op shows IDLE→ACCESS→DONE, 3 cycles per op.
  - The second op is not double-issued from DONE.
- Reset asserted mid-ACCESS:
  - dmem_req and stall_out drop asynchronously.
  - A stale ack after reset release produces no load_done.
  - Next LW completes normally.
